shiftreg_alu_seq: RTL and testbench



---
 rtl/shiftreg_alu_seq.sv | 113 +++++++++++
 tb/tb_shiftreg_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_alu_seq.sv
// Multi-cycle shift-register ALU: load, serial-fill left/right shift and
// shift-add multiply on W-bit operands, one bit-step per enabled clock.
module shiftreg_alu_seq #(
  parameter int W  = 3,
  parameter int CW = ($clog2(2*W+1) < 2) ? 2 : $clog2(2*W+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           ser_in,
  output logic [2*W-1:0] dout,
  output logic           busy,
  output logic           done
);

  localparam int DW = 2 * W;
  // The counter is loaded with a raw shift distance B, so it is never
  // allowed to be narrower than W even when CW would be.
  localparam int CNT_W = (CW > W) ? CW : W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    mcand;
  logic [W-1:0]     mplier;

  // NOTE: every register, including the multiplier working set, is reset so
  // an abandoned operation leaves no stale state behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      dout   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= op_t'(op);
            unique case (op_t'(op))
              OP_LOAD: begin
                dout  <= {B, A};
                count <= '0;
              end
              OP_SHL, OP_SHR: begin
                dout  <= {{W{1'b0}}, A};
                count <= CNT_W'(B);
              end
              OP_MUL: begin
                dout   <= '0;
                mcand  <= {{W{1'b0}}, A};
                mplier <= B;
                count  <= CNT_W'(W);
              end
            endcase
          end
        end

        RUN: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
            unique case (op_q)
              OP_SHL: dout <= {dout[DW-2:0], ser_in};
              OP_SHR: dout <= {ser_in, dout[DW-1:1]};
              OP_MUL: begin
                // Product of two W-bit values always fits in 2W bits.
                if (mplier[0]) dout <= dout + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
              end
              OP_LOAD: ;
            endcase
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_alu_seq.sv
// Scoreboard bench for shiftreg_alu_seq: directed plus randomized transactions
// against an arithmetic reference model, with a W=8 instance for wide cases.
module tb_shiftreg_alu_seq;

  localparam int W  = 3;
  localparam int DW = 2 * W;
  localparam logic [1:0] LOAD = 2'b00, SHL = 2'b01, SHR = 2'b10, MUL = 2'b11;

  logic          clk = 1'b0;
  logic          rst, en, start, ser_in;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic [DW-1:0] dout;
  logic          busy, done;

  logic          en8, start8, ser8;
  logic [1:0]    op8;
  logic [7:0]    a8, b8;
  logic [15:0]   dout8;
  logic          busy8, done8;

  always #5 clk = ~clk;

  shiftreg_alu_seq #(.W(W)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .op(op), .A(a), .B(b),
    .ser_in(ser_in), .dout(dout), .busy(busy), .done(done)
  );

  shiftreg_alu_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .start(start8), .op(op8), .A(a8), .B(b8),
    .ser_in(ser8), .dout(dout8), .busy(busy8), .done(done8)
  );

  typedef struct {
    longint res;
    int     steps;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, failures = 0;
  int   edges = 0, completions = 0, issued = 0;
  bit   issue_now = 1'b0, done_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result from the operation's meaning: shifts are plain shifts with the
  // vacated positions all taking the (constant) serial fill bit.
  function automatic longint model(input logic [1:0] o, input longint av, input longint bv,
                                   input bit s, input int w);
    int     dw   = 2 * w;
    longint full = (longint'(1) << dw) - 1;
    longint r;
    int     k;
    k = (bv >= dw) ? dw : int'(bv);
    case (o)
      LOAD:    r = (bv << w) | av;
      SHL:     r = (av << k) | (s ? ((longint'(1) << k) - 1) : longint'(0));
      SHR:     r = (av >> k) | (s ? (((longint'(1) << k) - 1) << (dw - k)) : longint'(0));
      default: r = av * bv;
    endcase
    return r & full;
  endfunction

  function automatic int model_steps(input logic [1:0] o, input longint bv, input int w);
    if (o == LOAD) return 0;
    if (o == MUL) return w;
    return int'(bv);
  endfunction

  // Enabled edges since the capture edge (which counts as the first).
  always @(posedge clk) begin
    if (rst) edges = 0;
    else if (issue_now) begin
      edges     = 1;
      issue_now = 1'b0;
    end else if (en) edges++;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      completions++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with dout=%0d, expected no completion", dout);
      end else begin
        e = sb_q.pop_front();
        check("dout", dout, e.res);
        check("latency", edges, e.steps + 2);
        check("busy_at_done", busy, 0);
      end
    end
    if (done !== 1'b1) done_seen = 1'b0;
  end

  task automatic run_txn(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit s, input bit rand_en);
    exp_t e;
    @(negedge clk);
    op = o; a = av; b = bv; ser_in = s; start = 1'b1; en = 1'b1; issue_now = 1'b1;
    e.res   = model(o, longint'(av), longint'(bv), s, W);
    e.steps = model_steps(o, longint'(bv), W);
    sb_q.push_back(e);
    issued++;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        start = 1'b0;
        en    = 1'b1;
        return;
      end
      en    = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rand_en) begin
        op = 2'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
      end
    end
    checks++;
    failures++;
    $display("FAIL timeout: op=%0d not idle after 400 cycles, expected completion", o);
    start = 1'b0;
    en    = 1'b1;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv, input bit s);
    int cyc = 0;
    @(negedge clk);
    op8 = o; a8 = av; b8 = bv; ser8 = s; start8 = 1'b1; en8 = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        cyc = i;
        break;
      end
    end
    check("w8_latency", cyc, model_steps(o, longint'(bv), 8) + 2);
    check("w8_dout", dout8, model(o, longint'(av), longint'(bv), s, 8));
    check("w8_busy_at_done", busy8, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; op = LOAD; a = '0; b = '0; ser_in = 1'b0;
    en8 = 1'b1; start8 = 1'b0; op8 = LOAD; a8 = '0; b8 = '0; ser8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    run_txn(LOAD, 3'b101, 3'b011, 1'b0, 1'b0);
    run_txn(SHL,  3'b001, 3'b011, 1'b0, 1'b0);
    run_txn(SHR,  3'b110, 3'b010, 1'b1, 1'b0);
    run_txn(MUL,  3'd7,   3'd7,   1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("dout_hold", dout, 49);
    run_txn(MUL,  3'd5,   3'd6,   1'b0, 1'b1);
    run_txn(SHL,  3'b101, 3'd0,   1'b1, 1'b0);
    run_txn(SHR,  3'b111, 3'd7,   1'b0, 1'b1);

    // Reset in the middle of a long shift abandons it without a done pulse.
    @(negedge clk);
    op = SHL; a = 3'b011; b = 3'd7; ser_in = 1'b1; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_dout", dout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    repeat (40) run_txn(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b1);

    run8(MUL, 8'd255, 8'd255, 1'b0);
    run8(MUL, 8'd13,  8'd200, 1'b0);
    run8(SHR, 8'hA5,  8'd200, 1'b1);
    run8(SHL, 8'hC3,  8'd5,   1'b1);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("completions", completions, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
